conv_mac_engine: RTL and testbench

- Parametrised successor to the single-shot 3x3 convolution unit.
- Holds a TAPS-element kernel and a TAPS-element window in registers, both loaded from the data bus by opcode.
- On START, performs a serial multiply-accumulate, one tap per clock, in signed or unsigned mode, with optional saturation.
- Presents the result on a valid/ready output port; sits between the bus-side op controller and the result bus.

---
 rtl/conv_mac_engine.sv | 163 ++++++++++++++++
 tb/tb_conv_mac_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_engine.sv
// Serial TAPS-element convolution MAC: kernel/window loaded by opcode, one tap per clock,
// signed/unsigned with optional saturation, result held on a valid/ready port.
module conv_mac_engine #(
  parameter int unsigned DW   = 8,
  parameter int unsigned TAPS = 9,
  parameter int unsigned OW   = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 select,
  input  logic [1:0]           opcode,
  input  logic [TAPS*DW-1:0]   fromDataBus,
  input  logic                 signed_mode,
  input  logic                 sat_en,
  output logic                 cmd_accept,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OW-1:0]        toDataBus
);

  localparam int unsigned AW = 2*DW + $clog2(TAPS);
  localparam int unsigned IW = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic [1:0] OP_LOAD_KERNEL = 2'b01;
  localparam logic [1:0] OP_LOAD_WINDOW = 2'b10;
  localparam logic [1:0] OP_START       = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                   r_state,  w_state_nxt;
  logic [TAPS-1:0][DW-1:0]  r_kernel, w_kernel_nxt;
  logic [TAPS-1:0][DW-1:0]  r_window, w_window_nxt;
  logic [AW-1:0]            r_acc,    w_acc_nxt;
  logic [IW-1:0]            r_idx,    w_idx_nxt;
  logic                     r_signed, w_signed_nxt;
  logic                     r_sat,    w_sat_nxt;
  logic [OW-1:0]            r_out,    w_out_nxt;
  logic                     r_accept, w_accept_nxt;
  logic                     r_busy;
  logic                     r_valid;

  logic [DW-1:0]            w_kel, w_wel;
  logic [AW-1:0]            w_kx, w_wx, w_prod, w_sum;
  logic [OW-1:0]            w_fmt;
  logic                     w_cmd_ok;
  logic                     w_do_start;

  // Current tap product, operands extended to AW per the latched mode
  always_comb begin
    w_kel  = r_kernel[r_idx];
    w_wel  = r_window[r_idx];
    w_kx   = r_signed ? {{(AW-DW){w_kel[DW-1]}}, w_kel} : {{(AW-DW){1'b0}}, w_kel};
    w_wx   = r_signed ? {{(AW-DW){w_wel[DW-1]}}, w_wel} : {{(AW-DW){1'b0}}, w_wel};
    w_prod = w_kx * w_wx;
    w_sum  = r_acc + w_prod;
  end

  // Final-sum formatting into OW bits
  if (OW >= AW) begin : g_extend
    always_comb w_fmt = r_signed ? OW'($signed(w_sum)) : OW'(w_sum);
  end else begin : g_narrow
    always_comb begin
      w_fmt = w_sum[OW-1:0];
      if (r_sat) begin
        if (r_signed) begin
          // Overflow when the bits above the OW-bit sign position are not a pure sign extension
          if (w_sum[AW-1:OW-1] != {(AW-OW+1){w_sum[AW-1]}}) begin
            w_fmt = w_sum[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
          end
        end else if (|w_sum[AW-1:OW]) begin
          w_fmt = '1;
        end
      end
    end
  end

  // Next-state and register-update logic
  always_comb begin
    w_state_nxt  = r_state;
    w_kernel_nxt = r_kernel;
    w_window_nxt = r_window;
    w_acc_nxt    = r_acc;
    w_idx_nxt    = r_idx;
    w_signed_nxt = r_signed;
    w_sat_nxt    = r_sat;
    w_out_nxt    = r_out;
    w_accept_nxt = 1'b0;
    w_do_start   = 1'b0;
    w_cmd_ok     = select && (r_state != S_MAC);

    if (w_cmd_ok && (opcode == OP_LOAD_KERNEL)) begin
      w_kernel_nxt = fromDataBus;
      w_accept_nxt = 1'b1;
    end
    if (w_cmd_ok && (opcode == OP_LOAD_WINDOW)) begin
      w_window_nxt = fromDataBus;
      w_accept_nxt = 1'b1;
    end
    if (w_cmd_ok && (opcode == OP_START) && ((r_state == S_IDLE) || out_ready)) begin
      w_do_start = 1'b1;
    end

    case (r_state)
      S_IDLE: ;
      S_MAC: begin
        w_acc_nxt = w_sum;
        w_idx_nxt = r_idx + IW'(1);
        if (r_idx == IW'(TAPS-1)) begin
          w_out_nxt   = w_fmt;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_do_start) begin
      w_acc_nxt    = '0;
      w_idx_nxt    = '0;
      w_signed_nxt = signed_mode;
      w_sat_nxt    = sat_en;
      w_accept_nxt = 1'b1;
      w_state_nxt  = S_MAC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_kernel <= '0;
      r_window <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_signed <= 1'b0;
      r_sat    <= 1'b0;
      r_out    <= '0;
      r_accept <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_kernel <= w_kernel_nxt;
      r_window <= w_window_nxt;
      r_acc    <= w_acc_nxt;
      r_idx    <= w_idx_nxt;
      r_signed <= w_signed_nxt;
      r_sat    <= w_sat_nxt;
      r_out    <= w_out_nxt;
      r_accept <= w_accept_nxt;
      r_busy   <= (w_state_nxt == S_MAC);
      r_valid  <= (w_state_nxt == S_DONE);
    end
  end

  assign cmd_accept = r_accept;
  assign busy       = r_busy;
  assign out_valid  = r_valid;
  assign toDataBus  = r_out;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Bench for conv_mac_engine: directed cases with literal results plus random kernels/windows
// checked against an integer-arithmetic reference model.
module tb_conv_mac_engine;

  localparam int DW   = 8;
  localparam int TAPS = 9;
  localparam int OW   = 18;
  localparam int BW   = DW*TAPS;

  localparam logic [1:0] OP_LK = 2'b01;
  localparam logic [1:0] OP_LW = 2'b10;
  localparam logic [1:0] OP_ST = 2'b11;

  logic           clk = 1'b0;
  logic           rst;
  logic           select;
  logic [1:0]     opcode;
  logic [BW-1:0]  fromDataBus;
  logic           signed_mode;
  logic           sat_en;
  logic           cmd_accept;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [OW-1:0]  toDataBus;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] mk [TAPS];
  logic [DW-1:0] mw [TAPS];

  conv_mac_engine #(.DW(DW), .TAPS(TAPS), .OW(OW)) dut (
    .clk(clk), .rst(rst), .select(select), .opcode(opcode), .fromDataBus(fromDataBus),
    .signed_mode(signed_mode), .sat_en(sat_en), .cmd_accept(cmd_accept), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .toDataBus(toDataBus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer dot product, then clamp or wrap to OW bits
  function automatic logic [OW-1:0] model(input logic sm, input logic se);
    longint s = 0;
    longint a, b;
    longint smax = (longint'(1) << (OW-1)) - 1;
    longint smin = -(longint'(1) << (OW-1));
    longint umax = (longint'(1) << OW) - 1;
    for (int i = 0; i < TAPS; i++) begin
      if (sm) begin
        a = longint'($signed(mk[i]));
        b = longint'($signed(mw[i]));
      end else begin
        a = longint'(mk[i]);
        b = longint'(mw[i]);
      end
      s += a * b;
    end
    if (se) begin
      if (sm) begin
        if (s > smax) s = smax;
        else if (s < smin) s = smin;
      end else if (s > umax) begin
        s = umax;
      end
    end
    return OW'(s);
  endfunction

  function automatic logic [BW-1:0] rnd_bus();
    return BW'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Called at a negedge; leaves time at the following negedge
  task automatic load(input logic [1:0] op, input logic [BW-1:0] data, input logic exp_acc,
                      input string tag);
    select      = 1'b1;
    opcode      = op;
    fromDataBus = data;
    @(negedge clk);
    chk({tag, "_accept"}, 64'(cmd_accept), 64'(exp_acc));
    select      = 1'b0;
    opcode      = 2'b00;
    fromDataBus = rnd_bus();
    if (exp_acc) begin
      for (int i = 0; i < TAPS; i++) begin
        if (op == OP_LK) mk[i] = data[i*DW +: DW];
        else             mw[i] = data[i*DW +: DW];
      end
    end
  endtask

  task automatic start(input logic sm, input logic se, input logic exp_acc, input string tag);
    select      = 1'b1;
    opcode      = OP_ST;
    signed_mode = sm;
    sat_en      = se;
    @(negedge clk);
    chk({tag, "_accept"}, 64'(cmd_accept), 64'(exp_acc));
    chk({tag, "_busy"}, 64'(busy), 64'(exp_acc));
    select      = 1'b0;
    opcode      = 2'b00;
    signed_mode = ~sm;
    sat_en      = ~se;
  endtask

  task automatic wait_result(input int exp_cyc, input logic [OW-1:0] exp_val, input string tag);
    int k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(exp_cyc));
    chk({tag, "_data"}, 64'(toDataBus), 64'(exp_val));
    chk({tag, "_busy_done"}, 64'(busy), 64'(0));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid_clr"}, 64'(out_valid), 64'(0));
    chk({tag, "_busy_idle"}, 64'(busy), 64'(0));
    out_ready = 1'b0;
  endtask

  initial begin
    logic [BW-1:0] kb, wb, wb2;
    logic [OW-1:0] held;
    logic          sm, se;

    rst = 1'b0; select = 1'b0; opcode = 2'b00; fromDataBus = '0;
    signed_mode = 1'b0; sat_en = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < TAPS; i++) begin mk[i] = '0; mw[i] = '0; end
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_accept", 64'(cmd_accept), 64'(0));
    chk("rst_data", 64'(toDataBus), 64'(0));
    rst = 1'b0;

    // Unsigned basic: kernel ones, window 1..9
    kb = {TAPS{8'h01}};
    for (int i = 0; i < TAPS; i++) wb[i*DW +: DW] = DW'(i + 1);
    load(OP_LK, kb, 1'b1, "ub_lk");
    load(OP_LW, wb, 1'b1, "ub_lw");
    start(1'b0, 1'b0, 1'b1, "ub_start");
    wait_result(9, 18'h0002D, "ub");
    consume("ub");

    // Signed: -1 * 127 * 9
    load(OP_LK, {TAPS{8'hFF}}, 1'b1, "sg_lk");
    load(OP_LW, {TAPS{8'h7F}}, 1'b1, "sg_lw");
    start(1'b1, 1'b1, 1'b1, "sg_start");
    wait_result(9, 18'h3FB89, "sg");
    consume("sg");

    // Unsigned overflow: saturate, then wrap
    load(OP_LK, {TAPS{8'hFF}}, 1'b1, "uo_lk");
    load(OP_LW, {TAPS{8'hFF}}, 1'b1, "uo_lw");
    start(1'b0, 1'b1, 1'b1, "uo_sat_start");
    wait_result(9, 18'h3FFFF, "uo_sat");
    consume("uo_sat");
    start(1'b0, 1'b0, 1'b1, "uo_wrap_start");
    wait_result(9, 18'h0EE09, "uo_wrap");
    consume("uo_wrap");

    // Signed saturation: (-128)*(-128)*9 = +147456
    load(OP_LK, {TAPS{8'h80}}, 1'b1, "ss_lk");
    load(OP_LW, {TAPS{8'h80}}, 1'b1, "ss_lw");
    start(1'b1, 1'b1, 1'b1, "ss_start");
    wait_result(9, 18'h1FFFF, "ss");
    consume("ss");

    // Async reset in the middle of a MAC
    start(1'b1, 1'b1, 1'b1, "rm_start");
    repeat (3) @(negedge clk);
    chk("rm_busy_pre", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("rm_busy", 64'(busy), 64'(0));
    chk("rm_valid", 64'(out_valid), 64'(0));
    chk("rm_data", 64'(toDataBus), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < TAPS; i++) begin mk[i] = '0; mw[i] = '0; end
    load(OP_LW, rnd_bus(), 1'b1, "rz_lw");
    start(1'b0, 1'b0, 1'b1, "rz_start");
    wait_result(9, '0, "rz");
    consume("rz");

    // Handshake corners
    kb  = rnd_bus();
    wb  = rnd_bus();
    wb2 = ~wb;
    load(OP_LK, kb, 1'b1, "hs_lk");
    load(OP_LW, wb, 1'b1, "hs_lw");
    start(1'b0, 1'b0, 1'b1, "hs_start");
    load(OP_LW, wb2, 1'b0, "hs_mac_lw");
    wait_result(8, model(1'b0, 1'b0), "hs_oldwin");
    held = model(1'b0, 1'b0);
    start(1'b1, 1'b0, 1'b0, "hs_rej");
    chk("hs_rej_valid", 64'(out_valid), 64'(1));
    chk("hs_rej_data", 64'(toDataBus), 64'(held));
    load(OP_LK, rnd_bus(), 1'b1, "hs_done_lk");
    chk("hs_lk_valid", 64'(out_valid), 64'(1));
    chk("hs_lk_data", 64'(toDataBus), 64'(held));
    out_ready = 1'b1;
    start(1'b0, 1'b1, 1'b1, "hs_b2b");
    out_ready = 1'b0;
    chk("hs_b2b_valid", 64'(out_valid), 64'(0));
    wait_result(9, model(1'b0, 1'b1), "hs_b2b");
    consume("hs_b2b");

    // Random kernels/windows and modes
    for (int t = 0; t < 10; t++) begin
      sm = 1'($urandom_range(0, 1));
      se = 1'($urandom_range(0, 1));
      load(OP_LK, rnd_bus(), 1'b1, "rn_lk");
      load(OP_LW, rnd_bus(), 1'b1, "rn_lw");
      start(sm, se, 1'b1, "rn_start");
      wait_result(9, model(sm, se), "rn");
      consume("rn");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
